// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game core.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } game_state_e;

   // Population count over a fixed-width vector; callers zero-extend (supports up to 64 moles).
   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + {6'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/mole_cell.sv
// One mole: active flag plus lifetime counter; classifies this cycle's whack/tick as hit, whiff or escape.
module mole_cell
   import mole_pkg::*;
#(
   parameter int LIFE_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic play,
   input  logic clear,
   input  logic tick,
   input  logic whack,
   input  logic spawn_req,
   output logic active,
   output logic hit,
   output logic whiff,
   output logic escape
);

   localparam int LW = $clog2(LIFE_TICKS + 1);

   logic          active_reg;
   logic [LW-1:0] life_reg;

   assign active = active_reg;
   assign hit    = play && whack && active_reg;
   assign whiff  = play && whack && !active_reg;
   // A whack on the expiring tick counts as a hit, never an escape.
   assign escape = play && tick && active_reg && !whack && (life_reg == LW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg <= 1'b0;
         life_reg   <= '0;
      end else if (clear) begin
         active_reg <= 1'b0;
         life_reg   <= '0;
      end else if (play) begin
         if (active_reg) begin
            if (hit || escape) begin
               active_reg <= 1'b0;
               life_reg   <= '0;
            end else if (tick) begin
               life_reg <= life_reg - LW'(1);
            end
         end else if (spawn_req) begin
            active_reg <= 1'b1;
            life_reg   <= LW'(LIFE_TICKS);
         end
      end
   end

endmodule

// File: rtl/mole_field.sv
// Whack-a-mole game core: switch edge detect, round FSM and timer, saturating score/miss counters.
module mole_field
   import mole_pkg::*;
#(
   parameter int N_MOLES     = 18,
   parameter int LIFE_TICKS  = 4,
   parameter int ROUND_TICKS = 60,
   parameter int MAX_MISSES  = 8,
   parameter int SCORE_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               start,
   input  logic [N_MOLES-1:0] sw,
   input  logic [N_MOLES-1:0] spawn,
   input  logic               spawn_valid,
   output logic [N_MOLES-1:0] led,
   output logic [N_MOLES-1:0] hit_pulse,
   output logic [N_MOLES-1:0] escape_pulse,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] misses,
   output logic [1:0]         state,
   output logic               game_over
);

   localparam int CNT_W = $clog2(N_MOLES + 1);
   localparam int SUM_W = CNT_W + SCORE_W;
   localparam int RT_W  = $clog2(ROUND_TICKS + 1);
   localparam logic [SUM_W-1:0] SAT = {{CNT_W{1'b0}}, {SCORE_W{1'b1}}};

   game_state_e        state_reg;
   logic [N_MOLES-1:0] prev_sw_reg;
   logic [N_MOLES-1:0] hit_pulse_reg;
   logic [N_MOLES-1:0] escape_pulse_reg;
   logic [SCORE_W-1:0] score_reg;
   logic [SCORE_W-1:0] misses_reg;
   logic [RT_W-1:0]    round_cnt_reg;
   logic               game_over_reg;

   logic [N_MOLES-1:0] whack;
   logic [N_MOLES-1:0] active;
   logic [N_MOLES-1:0] hit;
   logic [N_MOLES-1:0] whiff;
   logic [N_MOLES-1:0] escape;

   logic               play;
   logic               begin_round;
   logic               round_done;
   logic               max_hit;
   logic               end_round;
   logic               clear;
   logic [SUM_W-1:0]   score_sum;
   logic [SUM_W-1:0]   miss_sum;
   logic [SCORE_W-1:0] score_next;
   logic [SCORE_W-1:0] misses_next;

   assign whack       = sw ^ prev_sw_reg;
   assign play        = (state_reg == PLAY);
   assign begin_round = start && (state_reg != PLAY);

   generate
      for (genvar gi = 0; gi < N_MOLES; gi++) begin : g_cell
         mole_cell #(
            .LIFE_TICKS(LIFE_TICKS)
         ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .play      (play),
            .clear     (clear),
            .tick      (tick),
            .whack     (whack[gi]),
            .spawn_req (spawn_valid && spawn[gi]),
            .active    (active[gi]),
            .hit       (hit[gi]),
            .whiff     (whiff[gi]),
            .escape    (escape[gi])
         );
      end
   endgenerate

   // Whiff needs an idle mole and escape an active one, so OR-ing them counts both exactly.
   assign score_sum   = SUM_W'(score_reg) + SUM_W'(popcount(64'(hit)));
   assign miss_sum    = SUM_W'(misses_reg) + SUM_W'(popcount(64'(whiff | escape)));
   assign score_next  = (score_sum > SAT) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
   assign misses_next = (miss_sum > SAT) ? {SCORE_W{1'b1}} : miss_sum[SCORE_W-1:0];

   assign round_done = tick && (round_cnt_reg == RT_W'(1));
   assign max_hit    = (MAX_MISSES != 0) && (32'(misses_next) >= 32'(MAX_MISSES));
   assign end_round  = play && (round_done || max_hit);
   assign clear      = begin_round || end_round;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         prev_sw_reg      <= '0;
         hit_pulse_reg    <= '0;
         escape_pulse_reg <= '0;
         score_reg        <= '0;
         misses_reg       <= '0;
         round_cnt_reg    <= '0;
         game_over_reg    <= 1'b0;
      end else begin
         prev_sw_reg      <= sw;
         hit_pulse_reg    <= '0;
         escape_pulse_reg <= '0;
         case (state_reg)
            IDLE, OVER: begin
               if (start) begin
                  state_reg     <= PLAY;
                  game_over_reg <= 1'b0;
                  score_reg     <= '0;
                  misses_reg    <= '0;
                  round_cnt_reg <= RT_W'(ROUND_TICKS);
               end
            end
            PLAY: begin
               score_reg  <= score_next;
               misses_reg <= misses_next;
               if (tick) begin
                  round_cnt_reg <= round_cnt_reg - RT_W'(1);
               end
               // Final-cycle events are counted but their pulses are suppressed.
               if (end_round) begin
                  state_reg     <= OVER;
                  game_over_reg <= 1'b1;
               end else begin
                  hit_pulse_reg    <= hit;
                  escape_pulse_reg <= escape;
               end
            end
            default: begin
               state_reg     <= IDLE;
               game_over_reg <= 1'b0;
            end
         endcase
      end
   end

   assign led          = active;
   assign hit_pulse    = hit_pulse_reg;
   assign escape_pulse = escape_pulse_reg;
   assign score        = score_reg;
   assign misses       = misses_reg;
   assign state        = state_reg;
   assign game_over    = game_over_reg;

endmodule
